// File: rtl/l1_bus_requester_pkg.sv
// Shared types and helpers for the L1 snooping-bus requester: bus commands,
// MOESI line states, requester FSM states and the fill-state rule.
package l1_bus_requester_pkg;

    localparam int unsigned ADDR_BITS      = 32;
    localparam int unsigned OFFSET_BITS    = 6;
    localparam int unsigned CACHELINE_BITS = 512;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_req_t;

    typedef enum logic [2:0] {
        I = 3'd0,
        S = 3'd1,
        E = 3'd2,
        O = 3'd3,
        M = 3'd4
    } l1_state_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        BCAST   = 3'd2,
        SWAIT   = 3'd3,
        L2_REQ  = 3'd4,
        L2_WAIT = 3'd5,
        RESP    = 3'd6
    } req_state_t;

    // State the requesting L1 holds after its request completes.
    function automatic l1_state_t fill_state(input bus_req_t cmd, input logic shared);
        l1_state_t st;
        case (cmd)
            BUS_RD:   st = shared ? S : E;
            BUS_RDX:  st = M;
            BUS_UPGR: st = M;
            default:  st = I;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/l1_bus_requester.sv
// Initiator side of the L1 snooping bus: arbitrates, broadcasts, collects the
// combined snoop response, falls back to L2 and returns fill data + new state.
module l1_bus_requester
    import l1_bus_requester_pkg::*;
#(
    parameter int unsigned LINE_ADDR_W = ADDR_BITS - OFFSET_BITS,
    parameter int unsigned LINE_W      = CACHELINE_BITS,
    parameter int unsigned SNOOP_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   core_req_valid,
    output logic                   core_req_ready,
    input  bus_req_t               core_req_cmd,
    input  logic [LINE_ADDR_W-1:0] core_req_addr,
    input  logic [LINE_W-1:0]      core_wb_data,
    output logic                   core_resp_valid,
    output l1_state_t              core_resp_state,
    output logic [LINE_W-1:0]      core_resp_data,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic                   bus_valid,
    output logic [LINE_ADDR_W-1:0] bus_addr,
    output bus_req_t               bus_cmd,
    input  logic                   snoop_shared,
    input  logic [LINE_W-1:0]      snoop_data,
    output logic                   l2_valid,
    input  logic                   l2_ready,
    output bus_req_t               l2_cmd,
    output logic [LINE_ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0]      l2_wdata,
    input  logic                   l2_resp_valid,
    input  logic [LINE_W-1:0]      l2_resp_data
);

    localparam int unsigned CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;

    req_state_t             state, state_n;
    bus_req_t               cmd_q, cmd_n;
    bus_req_t               l2_cmd_n;
    logic [LINE_ADDR_W-1:0] addr_q, addr_n;
    logic [LINE_W-1:0]      wb_q, wb_n;
    logic [LINE_W-1:0]      data_q, data_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    l1_state_t              resp_state_n;
    logic                   ready_n, resp_valid_n, bus_req_n, bus_valid_n, l2_valid_n;

    // Address, command and write data are driven straight from the latched request.
    assign bus_addr       = addr_q;
    assign bus_cmd        = cmd_q;
    assign l2_addr        = addr_q;
    assign l2_wdata       = wb_q;
    assign core_resp_data = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cmd_q           <= BUS_RD;
            addr_q          <= '0;
            wb_q            <= '0;
            data_q          <= '0;
            cnt_q           <= '0;
            l2_cmd          <= BUS_RD;
            core_resp_state <= I;
            core_req_ready  <= 1'b0;
            core_resp_valid <= 1'b0;
            bus_req         <= 1'b0;
            bus_valid       <= 1'b0;
            l2_valid        <= 1'b0;
        end else begin
            state           <= state_n;
            cmd_q           <= cmd_n;
            addr_q          <= addr_n;
            wb_q            <= wb_n;
            data_q          <= data_n;
            cnt_q           <= cnt_n;
            l2_cmd          <= l2_cmd_n;
            core_resp_state <= resp_state_n;
            core_req_ready  <= ready_n;
            core_resp_valid <= resp_valid_n;
            bus_req         <= bus_req_n;
            bus_valid       <= bus_valid_n;
            l2_valid        <= l2_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        cmd_n        = cmd_q;
        addr_n       = addr_q;
        wb_n         = wb_q;
        data_n       = data_q;
        cnt_n        = cnt_q;
        l2_cmd_n     = l2_cmd;
        resp_state_n = core_resp_state;

        case (state)
            IDLE: begin
                if (core_req_valid && core_req_ready) begin
                    cmd_n    = core_req_cmd;
                    addr_n   = core_req_addr;
                    wb_n     = core_wb_data;
                    l2_cmd_n = (core_req_cmd == BUS_WB) ? BUS_WB : BUS_RD;
                    state_n  = (core_req_cmd == BUS_WB) ? L2_REQ : ARB;
                end
            end
            ARB: begin
                if (bus_gnt) begin
                    state_n = BCAST;
                end
            end
            BCAST: begin
                if (cmd_q == BUS_UPGR) begin
                    resp_state_n = fill_state(cmd_q, 1'b0);
                    state_n      = RESP;
                end else begin
                    cnt_n   = CNT_W'(SNOOP_LAT - 1);
                    state_n = SWAIT;
                end
            end
            SWAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else if (snoop_shared) begin
                    data_n       = snoop_data;
                    resp_state_n = fill_state(cmd_q, 1'b1);
                    state_n      = RESP;
                end else begin
                    state_n = L2_REQ;
                end
            end
            L2_REQ: begin
                if (l2_ready) begin
                    state_n = L2_WAIT;
                end
            end
            L2_WAIT: begin
                if (l2_resp_valid) begin
                    if (cmd_q != BUS_WB) begin
                        data_n = l2_resp_data;
                    end
                    resp_state_n = fill_state(cmd_q, 1'b0);
                    state_n      = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Outputs are registered against the state being entered.
        ready_n      = (state_n == IDLE);
        resp_valid_n = (state_n == RESP);
        bus_valid_n  = (state_n == BCAST);
        l2_valid_n   = (state_n == L2_REQ);
        // Writebacks never touch the bus; everything else owns it until RESP ends.
        bus_req_n    = (state_n != IDLE) && (cmd_n != BUS_WB);
    end

endmodule

// File: tb/tb_l1_bus_requester.sv
// Scoreboard bench for l1_bus_requester: directed transactions push expected
// broadcasts, L2 requests and responses; negedge monitors pop and compare.
module tb_l1_bus_requester;
    import l1_bus_requester_pkg::*;

    localparam int unsigned AW = ADDR_BITS - OFFSET_BITS;
    localparam int unsigned DW = CACHELINE_BITS;

    localparam logic [DW-1:0] D_DEAD = DW'({16{32'hDEADBEEF}});
    localparam logic [DW-1:0] D_BEEF = DW'({16{32'hBEEFCAFE}});
    localparam logic [DW-1:0] D_L2X  = DW'({16{32'h0BADF00D}});
    localparam logic [DW-1:0] D_OWN  = DW'({16{32'h12345678}});
    localparam logic [DW-1:0] D_WB   = DW'({64{8'h55}});
    localparam logic [DW-1:0] D_JUNK = DW'({16{32'hA5A5A5A5}});

    logic            clk;
    logic            reset_n;
    logic            core_req_valid;
    logic            core_req_ready;
    bus_req_t        core_req_cmd;
    logic [AW-1:0]   core_req_addr;
    logic [DW-1:0]   core_wb_data;
    logic            core_resp_valid;
    l1_state_t       core_resp_state;
    logic [DW-1:0]   core_resp_data;
    logic            bus_req;
    logic            bus_gnt;
    logic            bus_valid;
    logic [AW-1:0]   bus_addr;
    bus_req_t        bus_cmd;
    logic            snoop_shared;
    logic [DW-1:0]   snoop_data;
    logic            l2_valid;
    logic            l2_ready;
    bus_req_t        l2_cmd;
    logic [AW-1:0]   l2_addr;
    logic [DW-1:0]   l2_wdata;
    logic            l2_resp_valid;
    logic [DW-1:0]   l2_resp_data;

    l1_bus_requester dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .core_req_valid  (core_req_valid),
        .core_req_ready  (core_req_ready),
        .core_req_cmd    (core_req_cmd),
        .core_req_addr   (core_req_addr),
        .core_wb_data    (core_wb_data),
        .core_resp_valid (core_resp_valid),
        .core_resp_state (core_resp_state),
        .core_resp_data  (core_resp_data),
        .bus_req         (bus_req),
        .bus_gnt         (bus_gnt),
        .bus_valid       (bus_valid),
        .bus_addr        (bus_addr),
        .bus_cmd         (bus_cmd),
        .snoop_shared    (snoop_shared),
        .snoop_data      (snoop_data),
        .l2_valid        (l2_valid),
        .l2_ready        (l2_ready),
        .l2_cmd          (l2_cmd),
        .l2_addr         (l2_addr),
        .l2_wdata        (l2_wdata),
        .l2_resp_valid   (l2_resp_valid),
        .l2_resp_data    (l2_resp_data)
    );

    typedef struct {
        l1_state_t     st;
        logic [DW-1:0] data;
        bit            chk_data;
        int            span;
    } resp_exp_t;

    typedef struct {
        bus_req_t      cmd;
        logic [AW-1:0] addr;
    } bcast_exp_t;

    typedef struct {
        bus_req_t      cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            chk_wdata;
    } l2_exp_t;

    resp_exp_t  resp_q[$];
    bcast_exp_t bcast_q[$];
    l2_exp_t    l2_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit bus_req_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_resp(input l1_state_t st, input logic [DW-1:0] d, input bit cd, input int span);
        resp_exp_t e;
        e.st = st; e.data = d; e.chk_data = cd; e.span = span;
        resp_q.push_back(e);
    endtask

    task automatic push_bcast(input bus_req_t c, input logic [AW-1:0] a);
        bcast_exp_t e;
        e.cmd = c; e.addr = a;
        bcast_q.push_back(e);
    endtask

    task automatic push_l2(input bus_req_t c, input logic [AW-1:0] a, input logic [DW-1:0] w, input bit cw);
        l2_exp_t e;
        e.cmd = c; e.addr = a; e.wdata = w; e.chk_wdata = cw;
        l2_q.push_back(e);
    endtask

    // Monitor: compares every DUT-initiated event against the scoreboard queues.
    initial begin
        bit        prev_rv, prev_bv, prev_l2v;
        l2_exp_t   cur_l2;
        resp_exp_t er;
        bcast_exp_t eb;
        prev_rv = 0; prev_bv = 0; prev_l2v = 0;
        cur_l2.cmd = BUS_RD; cur_l2.addr = '0; cur_l2.wdata = '0; cur_l2.chk_wdata = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_rv = 0; prev_bv = 0; prev_l2v = 0;
            end else begin
                if (bus_req) bus_req_seen = 1;
                if (core_resp_valid) begin
                    chk("resp_pulse_width", DW'(prev_rv), DW'(0));
                    chk("resp_expected", DW'(resp_q.size() != 0), DW'(1));
                    if (resp_q.size() != 0) begin
                        er = resp_q.pop_front();
                        chk("resp_state", DW'(core_resp_state), DW'(er.st));
                        if (er.chk_data) chk("resp_data", core_resp_data, er.data);
                        if (er.span != 0) chk("resp_span", DW'(cyc - acc_cyc + 1), DW'(er.span));
                    end
                end
                if (bus_valid) begin
                    chk("bcast_pulse_width", DW'(prev_bv), DW'(0));
                    chk("bcast_expected", DW'(bcast_q.size() != 0), DW'(1));
                    if (bcast_q.size() != 0) begin
                        eb = bcast_q.pop_front();
                        chk("bcast_cmd", DW'(bus_cmd), DW'(eb.cmd));
                        chk("bcast_addr", DW'(bus_addr), DW'(eb.addr));
                        chk("bcast_bus_req", DW'(bus_req), DW'(1));
                    end
                end
                if (l2_valid && !prev_l2v) begin
                    chk("l2_expected", DW'(l2_q.size() != 0), DW'(1));
                    if (l2_q.size() != 0) begin
                        cur_l2 = l2_q.pop_front();
                        chk("l2_cmd", DW'(l2_cmd), DW'(cur_l2.cmd));
                        chk("l2_addr", DW'(l2_addr), DW'(cur_l2.addr));
                        if (cur_l2.chk_wdata) chk("l2_wdata", l2_wdata, cur_l2.wdata);
                    end
                end else if (l2_valid) begin
                    chk("l2_hold_cmd_addr", DW'({l2_cmd, l2_addr}), DW'({cur_l2.cmd, cur_l2.addr}));
                    if (cur_l2.chk_wdata) chk("l2_hold_wdata", l2_wdata, cur_l2.wdata);
                end
                prev_rv  = core_resp_valid;
                prev_bv  = bus_valid;
                prev_l2v = l2_valid;
            end
        end
    end

    // Present one request at a negedge while ready; returns one cycle later.
    task automatic issue(input bus_req_t c, input logic [AW-1:0] a, input logic [DW-1:0] wb);
        int n = 0;
        while (!core_req_ready && n < 50) begin @(negedge clk); n++; end
        chk("ready_timeout", DW'(core_req_ready), DW'(1));
        core_req_valid = 1; core_req_cmd = c; core_req_addr = a; core_wb_data = wb;
        acc_cyc = cyc;
        @(negedge clk);
        core_req_valid = 0; core_req_cmd = BUS_RD; core_req_addr = '0; core_wb_data = '0;
    endtask

    // Grant after gnt_dly cycles, then answer the snoop one cycle after the broadcast.
    task automatic serve_bus(input int gnt_dly, input bit upgr, input bit shared, input logic [DW-1:0] sd);
        int n = 0;
        while (!bus_req && n < 50) begin @(negedge clk); n++; end
        chk("bus_req_timeout", DW'(bus_req), DW'(1));
        repeat (gnt_dly) @(negedge clk);
        bus_gnt = 1;
        n = 0;
        while (!bus_valid && n < 50) begin @(negedge clk); n++; end
        chk("bus_valid_timeout", DW'(bus_valid), DW'(1));
        snoop_shared = 1; snoop_data = D_JUNK;   // broadcast cycle: must be ignored
        @(negedge clk);
        snoop_shared = upgr ? 1'b0 : shared;
        snoop_data   = upgr ? '0 : sd;
        @(negedge clk);
        snoop_shared = 0; snoop_data = '0;
    endtask

    task automatic serve_l2_req(input int rdy_dly);
        int n = 0;
        while (!l2_valid && n < 50) begin @(negedge clk); n++; end
        chk("l2_valid_timeout", DW'(l2_valid), DW'(1));
        if (rdy_dly > 0) begin
            l2_resp_valid = 1; l2_resp_data = D_JUNK;   // outside L2_WAIT: ignored
        end
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            l2_resp_valid = 0; l2_resp_data = '0;
        end
        l2_ready = 1;
        @(negedge clk);
        l2_ready = 0;
    endtask

    task automatic l2_reply(input logic [DW-1:0] d);
        @(negedge clk);
        l2_resp_valid = 1; l2_resp_data = d;
        @(negedge clk);
        l2_resp_valid = 0; l2_resp_data = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!core_req_ready && n < 50) begin @(negedge clk); n++; end
        chk("idle_timeout", DW'(core_req_ready), DW'(1));
        chk("bus_req_dropped_in_idle", DW'(bus_req), DW'(0));
        bus_gnt = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, DW'({core_req_ready, core_resp_valid, core_resp_state, bus_req,
                                 bus_valid, bus_cmd, l2_valid, l2_cmd}), DW'(0));
        chk({tag, "_addr"}, DW'({bus_addr, l2_addr}), DW'(0));
        chk({tag, "_resp_data"}, core_resp_data, '0);
        chk({tag, "_l2_wdata"}, l2_wdata, '0);
    endtask

    initial begin
        reset_n = 0; core_req_valid = 0; core_req_cmd = BUS_RD; core_req_addr = '0;
        core_wb_data = '0; bus_gnt = 0; snoop_shared = 0; snoop_data = '0;
        l2_ready = 0; l2_resp_valid = 0; l2_resp_data = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1;
        @(negedge clk);
        chk("idle_ready", DW'(core_req_ready), DW'(1));

        // RD, grant after 2 cycles, peer supplies the line -> S, no L2
        push_bcast(BUS_RD, AW'(26'h1A2));
        push_resp(S, D_DEAD, 1, 0);
        issue(BUS_RD, AW'(26'h1A2), '0);
        serve_bus(2, 0, 1, D_DEAD);
        wait_idle();

        // RD, no sharer -> L2 fetch after 3 ready-wait cycles -> E
        push_bcast(BUS_RD, AW'(26'h1A2));
        push_l2(BUS_RD, AW'(26'h1A2), '0, 0);
        push_resp(E, D_BEEF, 1, 0);
        issue(BUS_RD, AW'(26'h1A2), '0);
        serve_bus(1, 0, 0, '0);
        serve_l2_req(3);
        l2_reply(D_BEEF);
        wait_idle();

        // RDX with only S sharers (no shared) -> L2 fetch -> M
        push_bcast(BUS_RDX, AW'(26'h2B4));
        push_l2(BUS_RD, AW'(26'h2B4), '0, 0);
        push_resp(M, D_L2X, 1, 0);
        issue(BUS_RDX, AW'(26'h2B4), '0);
        serve_bus(0, 0, 0, '0);
        serve_l2_req(0);
        l2_reply(D_L2X);
        wait_idle();

        // RDX with an M owner supplying data -> M, no L2
        push_bcast(BUS_RDX, AW'(26'h2B4));
        push_resp(M, D_OWN, 1, 0);
        issue(BUS_RDX, AW'(26'h2B4), '0);
        serve_bus(0, 0, 1, D_OWN);
        wait_idle();

        // UPGR, immediate grant: accept cycle through resp cycle spans 4 cycles
        push_bcast(BUS_UPGR, AW'(26'h0C8));
        push_resp(M, '0, 0, 4);
        issue(BUS_UPGR, AW'(26'h0C8), '0);
        serve_bus(0, 1, 0, '0);
        wait_idle();

        // WB: straight to L2, no bus activity -> I
        bus_req_seen = 0;
        push_l2(BUS_WB, AW'(26'h3FF), D_WB, 1);
        push_resp(I, '0, 0, 0);
        issue(BUS_WB, AW'(26'h3FF), D_WB);
        serve_l2_req(2);
        l2_reply('0);
        wait_idle();
        chk("wb_no_bus_req", DW'(bus_req_seen), DW'(0));

        // Reset during L2_WAIT with a second request held while busy
        push_bcast(BUS_RD, AW'(26'h0F0));
        push_l2(BUS_RD, AW'(26'h0F0), '0, 0);
        issue(BUS_RD, AW'(26'h0F0), '0);
        serve_bus(1, 0, 0, '0);
        serve_l2_req(0);
        core_req_valid = 1; core_req_cmd = BUS_UPGR; core_req_addr = AW'(26'h333);
        for (int i = 0; i < 3; i++) begin
            chk("busy_not_ready", DW'(core_req_ready), DW'(0));
            @(negedge clk);
        end
        #2 reset_n = 0;
        #1 chk_all_zero("async_reset");
        bus_gnt = 0;
        @(negedge clk);
        reset_n = 1;
        push_bcast(BUS_UPGR, AW'(26'h333));
        push_resp(M, '0, 0, 0);
        begin
            int n = 0;
            while (!core_req_ready && n < 50) begin @(negedge clk); n++; end
            chk("post_reset_ready", DW'(core_req_ready), DW'(1));
            acc_cyc = cyc;
            @(negedge clk);
            core_req_valid = 0; core_req_cmd = BUS_RD; core_req_addr = '0;
        end
        serve_bus(0, 1, 0, '0);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("resp_q_drained", DW'(resp_q.size()), DW'(0));
        chk("bcast_q_drained", DW'(bcast_q.size()), DW'(0));
        chk("l2_q_drained", DW'(l2_q.size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
